// File: rtl/aiv_pkg.sv
// aiv_pkg: shared types and default AIV timing for the pixel sampler.
// Holds the line state enum, timing constants and a 2-of-3 vote helper.
package aiv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PORCH  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } aivState_e;

  localparam int unsigned AIV_ACC_W        = 16;
  localparam int unsigned AIV_PHASE_INC    = 12945;
  localparam int unsigned AIV_PHASE_OFFSET = 32768;
  localparam int unsigned AIV_H_START      = 96;
  localparam int unsigned AIV_H_ACTIVE     = 640;
  localparam int unsigned AIV_LINE_TIMEOUT = 6000;

  function automatic logic [2:0] maj3(
    input logic [2:0] a,
    input logic [2:0] b,
    input logic [2:0] c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/aiv_pixel_sampler_if.sv
// aiv_pixel_sampler_if: AIV input and framebuffer-side pixel bundle.
// master = sampler (takes hsync/rgb_in, drives pixel outputs); slave = peer.
interface aiv_pixel_sampler_if;
  logic       hsync;
  logic [2:0] rgb_in;
  logic       pixel_valid;
  logic [2:0] rgb_out;
  logic [9:0] pixel_x;
  logic       line_active;
  logic       sync_lost;

  modport master (
    input  hsync, rgb_in,
    output pixel_valid, rgb_out, pixel_x,
    output line_active, sync_lost
  );

  modport slave (
    output hsync, rgb_in,
    input  pixel_valid, rgb_out, pixel_x,
    input  line_active, sync_lost
  );
endinterface

// File: rtl/aiv_phase_nco.sv
// aiv_phase_nco: fractional phase accumulator, one tick per carry out.
// Ports: clk, reset (sync, high), load (re-phase to OFFSET), tick.
module aiv_phase_nco
  import aiv_pkg::*;
#(
  parameter int unsigned ACC_W  = AIV_ACC_W,
  parameter int unsigned INC    = AIV_PHASE_INC,
  parameter int unsigned OFFSET = AIV_PHASE_OFFSET
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum  = {1'b0, acc} + (ACC_W+1)'(INC);
  // a load cycle re-phases the grid, so its carry is dropped
  assign tick = sum[ACC_W] & ~load;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(OFFSET);
    end else begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/aiv_pixel_sampler.sv
// aiv_pixel_sampler: recovers the AIV dot grid, one strobe per source dot.
// Ports: clk, reset (sync, high), bus (master): hsync, rgb_in in;
// pixel_valid, rgb_out, pixel_x, line_active, sync_lost out.
// Option AIV_SAMPLER_MAJORITY_EN: 2-of-3 vote over the last 3 samples.
module aiv_pixel_sampler
  import aiv_pkg::*;
#(
  parameter int unsigned ACC_W        = AIV_ACC_W,
  parameter int unsigned PHASE_INC    = AIV_PHASE_INC,
  parameter int unsigned PHASE_OFFSET = AIV_PHASE_OFFSET,
  parameter int unsigned H_START      = AIV_H_START,
  parameter int unsigned H_ACTIVE     = AIV_H_ACTIVE,
  parameter int unsigned LINE_TIMEOUT = AIV_LINE_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  aiv_pixel_sampler_if.master bus
);

  localparam int unsigned TW = $clog2(LINE_TIMEOUT + 1);

  generate
    if (H_ACTIVE == 0 || H_ACTIVE > 1024) begin : gBadActive
      $error("H_ACTIVE must be in 1..1024");
    end
    if (H_START == 0 || H_START > 1024) begin : gBadStart
      $error("H_START must be in 1..1024");
    end
  endgenerate

  logic          hsyncQ;
  logic          lineStart;
  logic          dotTick;
  logic          timeout;
  logic [TW-1:0] toCnt;
  logic [TW-1:0] toNext;
  logic [9:0]    tickCnt;
  logic [9:0]    xCnt;
  logic [2:0]    sample;
  aivState_e     state;

  assign lineStart = hsyncQ & ~bus.hsync;

  aiv_phase_nco #(
    .ACC_W  (ACC_W),
    .INC    (PHASE_INC),
    .OFFSET (PHASE_OFFSET)
  ) uNco (
    .clk   (clk),
    .reset (reset),
    .load  (lineStart),
    .tick  (dotTick)
  );

`ifdef AIV_SAMPLER_MAJORITY_EN
  logic [2:0] hist1;
  logic [2:0] hist2;

  always_ff @(posedge clk) begin
    hist1 <= bus.rgb_in;
    hist2 <= hist1;
  end

  assign sample = maj3(hist2, hist1, bus.rgb_in);
`else
  assign sample = bus.rgb_in;
`endif

  always_comb begin
    toNext = toCnt;
    if (lineStart) begin
      toNext = '0;
    end else if (toCnt != TW'(LINE_TIMEOUT)) begin
      toNext = toCnt + TW'(1);
    end
  end

  assign timeout = (toNext == TW'(LINE_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      hsyncQ          <= 1'b0;
      state           <= IDLE;
      toCnt           <= '0;
      tickCnt         <= '0;
      xCnt            <= '0;
      bus.pixel_valid <= 1'b0;
      bus.rgb_out     <= '0;
      bus.pixel_x     <= '0;
      bus.line_active <= 1'b0;
      bus.sync_lost   <= 1'b1;
    end else begin
      hsyncQ          <= bus.hsync;
      toCnt           <= toNext;
      bus.pixel_valid <= 1'b0;
      if (lineStart) begin
        // also the early-restart path: no flush of a partial line
        state           <= PORCH;
        tickCnt         <= '0;
        xCnt            <= '0;
        bus.pixel_x     <= '0;
        bus.line_active <= 1'b0;
        bus.sync_lost   <= 1'b0;
      end else if (timeout) begin
        state           <= IDLE;
        bus.pixel_x     <= '0;
        bus.line_active <= 1'b0;
        bus.sync_lost   <= 1'b1;
      end else begin
        if (state == DONE) begin
          bus.line_active <= 1'b0;
        end
        if (dotTick) begin
          unique case (state)
            PORCH: begin
              if (tickCnt == 10'(H_START - 1)) begin
                state <= ACTIVE;
                xCnt  <= '0;
              end else begin
                tickCnt <= tickCnt + 10'd1;
              end
            end
            ACTIVE: begin
              bus.pixel_valid <= 1'b1;
              bus.pixel_x     <= xCnt;
              bus.rgb_out     <= sample;
              bus.line_active <= 1'b1;
              if (xCnt == 10'(H_ACTIVE - 1)) begin
                state <= DONE;
              end else begin
                xCnt <= xCnt + 10'd1;
              end
            end
            IDLE, DONE: ;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
